// File: rtl/dwc_pipeline_checker.sv
// dwc_pipeline_checker
// --------------------
// Duplication-with-comparison wrapper around a DEPTH-stage, WIDTH-bit
// registered pipeline. Two structurally separate copies (A and B) see the
// same input stream. Their final stages are compared every cycle, and any
// disagreement is reported as a single-cycle pulse, a sticky flag and a
// saturating event counter.
//
// Ports
//   port_clk           in   clock, rising edge
//   port_rst_n         in   asynchronous active-low reset
//   port_in_valid      in   input sample valid
//   port_in[WIDTH]     in   input sample
//   port_clear         in   synchronous clear of sticky flag and counter
//   port_out_valid     out  copy A final-stage valid
//   port_out[WIDTH]    out  copy A final-stage data
//   port_error         out  this-cycle mismatch of the final stages
//   port_error_sticky  out  latched error flag
//   port_error_count   out  saturating count of error cycles
//
// Handshake: valid-only streaming with no backpressure. port_in is taken on
// every rising edge where port_in_valid=1. port_out is meaningful on every
// cycle where port_out_valid=1, exactly DEPTH cycles later. While valid=0
// the data registers hold their last value.

module dwc_pipeline_checker #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             port_clk,
  input  logic             port_rst_n,
  input  logic             port_in_valid,
  input  logic [WIDTH-1:0] port_in,
  input  logic             port_clear,
  output logic             port_out_valid,
  output logic [WIDTH-1:0] port_out,
  output logic             port_error,
  output logic             port_error_sticky,
  output logic [CNT_W-1:0] port_error_count
);

  // Copy A: the functional pipeline that drives the outputs.
  logic [DEPTH-1:0]            a_valid_q, a_valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] a_data_q,  a_data_d;

  // Copy B: the redundant pipeline. It feeds only the comparator. The
  // attributes stop synthesis from recognising it as a duplicate of copy A
  // and merging the two, which would remove the redundancy.
  (* keep = "true", dont_touch = "true" *) logic [DEPTH-1:0]            b_valid_q;
  (* keep = "true", dont_touch = "true" *) logic [DEPTH-1:0][WIDTH-1:0] b_data_q;
  logic [DEPTH-1:0]            b_valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] b_data_d;

  // Final-stage taps of both copies.
  logic             a_fin_valid, b_fin_valid;
  logic [WIDTH-1:0] a_fin_data,  b_fin_data;

  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [CNT_W-1:0] count_base;

  // Pipeline next-state. Both copies use the same rule but are written out
  // separately so that they remain independent register sets.
  always_comb begin
    a_valid_d = a_valid_q;
    a_data_d  = a_data_q;
    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;

    a_valid_d[0] = port_in_valid;
    b_valid_d[0] = port_in_valid;
    if (port_in_valid) begin
      a_data_d[0] = port_in;
      b_data_d[0] = port_in;
    end

    for (int k = 1; k < DEPTH; k++) begin
      a_valid_d[k] = a_valid_q[k-1];
      b_valid_d[k] = b_valid_q[k-1];
      // Data advances only behind a valid, so bubbles leave the data in place.
      if (a_valid_q[k-1]) a_data_d[k] = a_data_q[k-1];
      if (b_valid_q[k-1]) b_data_d[k] = b_data_q[k-1];
    end
  end

  always_ff @(posedge port_clk or negedge port_rst_n) begin
    if (!port_rst_n) begin
      a_valid_q <= '0;
      a_data_q  <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_data_q  <= a_data_d;
    end
  end

  always_ff @(posedge port_clk or negedge port_rst_n) begin
    if (!port_rst_n) begin
      b_valid_q <= '0;
      b_data_q  <= '0;
    end else begin
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
    end
  end

  assign a_fin_valid = a_valid_q[DEPTH-1];
  assign a_fin_data  = a_data_q[DEPTH-1];
  assign b_fin_valid = b_valid_q[DEPTH-1];
  assign b_fin_data  = b_data_q[DEPTH-1];

  // A valid disagreement is always an error. A data disagreement counts only
  // when both copies claim a valid sample; stale data under bubbles is ignored.
  assign port_error = (a_fin_valid != b_fin_valid)
                    | (a_fin_valid & b_fin_valid & (a_fin_data != b_fin_data));

  // The sticky flag and the counter clear first, then the current error is
  // applied, so an error coinciding with port_clear is still recorded.
  always_comb begin
    sticky_d   = port_error | (sticky_q & ~port_clear);
    count_base = port_clear ? '0 : count_q;
    count_d    = count_base;
    if (port_error && (count_base != {CNT_W{1'b1}})) begin
      count_d = count_base + CNT_W'(1);
    end
  end

  always_ff @(posedge port_clk or negedge port_rst_n) begin
    if (!port_rst_n) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign port_out_valid    = a_fin_valid;
  assign port_out          = a_fin_data;
  assign port_error_sticky = sticky_q;
  assign port_error_count  = count_q;

endmodule

// File: tb/tb_dwc_pipeline_checker.sv
// Testbench for dwc_pipeline_checker. Two instances share their inputs: one
// with default parameters and one with a 2-bit counter, so that saturation is
// reachable. Faults are forced onto copy B's final-stage taps. The reference
// model treats the pipeline as a DEPTH-cycle delay queue of input samples and
// applies the comparator, sticky and counter rules arithmetically.

module tb_dwc_pipeline_checker;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int CNT_S = 2;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             clear;

  logic             out_valid, out_valid_s;
  logic [WIDTH-1:0] out_data, out_data_s;
  logic             err, err_s;
  logic             sticky, sticky_s;
  logic [CNT_W-1:0] count;
  logic [CNT_S-1:0] count_s;

  dwc_pipeline_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .port_clk          (clk),
    .port_rst_n        (rst_n),
    .port_in_valid     (in_valid),
    .port_in           (in_data),
    .port_clear        (clear),
    .port_out_valid    (out_valid),
    .port_out          (out_data),
    .port_error        (err),
    .port_error_sticky (sticky),
    .port_error_count  (count)
  );

  dwc_pipeline_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_S)) dut_sat (
    .port_clk          (clk),
    .port_rst_n        (rst_n),
    .port_in_valid     (in_valid),
    .port_in           (in_data),
    .port_clear        (clear),
    .port_out_valid    (out_valid_s),
    .port_out          (out_data_s),
    .port_error        (err_s),
    .port_error_sticky (sticky_s),
    .port_error_count  (count_s)
  );

  // Scoreboard / reference model state
  int n_checks = 0;
  int n_errors = 0;

  logic             exp_q_v[$];
  logic [WIDTH-1:0] exp_q[$];
  logic             m_v;
  logic [WIDTH-1:0] m_d;
  logic             m_sticky;
  int               m_cnt;
  int               m_cnt_s;

  // Values driven onto copy B taps while a fault is active.
  logic             f_valid;
  logic [WIDTH-1:0] f_data;

  localparam int FLT_NONE  = 0;
  localparam int FLT_DATA  = 1;
  localparam int FLT_VALID = 2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q_v.delete();
    exp_q.delete();
    m_v      = 1'b0;
    m_d      = '0;
    m_sticky = 1'b0;
    m_cnt    = 0;
    m_cnt_s  = 0;
  endtask

  // Driver: one clock cycle. Entered and left just after a falling edge.
  // mode selects a fault on copy B's final stage for this cycle; for a data
  // fault, mask is XORed into the data copy A currently shows.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic clr,
                      input int mode, input logic [WIDTH-1:0] mask);
    logic             vb;
    logic [WIDTH-1:0] db;
    logic             exp_err;
    logic             pv;
    logic [WIDTH-1:0] pd;
    in_valid = v;
    in_data  = d;
    clear    = clr;
    vb = m_v;
    db = m_d;
    if (mode == FLT_DATA) begin
      db     = m_d ^ mask;
      f_data = db;
      force dut.b_fin_data     = f_data;
      force dut_sat.b_fin_data = f_data;
    end else if (mode == FLT_VALID) begin
      vb      = ~m_v;
      f_valid = vb;
      force dut.b_fin_valid     = f_valid;
      force dut_sat.b_fin_valid = f_valid;
    end
    #1;
    exp_err = (m_v != vb) || (m_v && vb && (m_d != db));
    check("out_valid", 32'(out_valid), 32'(m_v));
    check("out_data",  32'(out_data),  32'(m_d));
    check("error",     32'(err),       32'(exp_err));
    check("sticky",    32'(sticky),    32'(m_sticky));
    check("count",     32'(count),     32'(m_cnt));
    check("sat_error", 32'(err_s),     32'(exp_err));
    check("sat_count", 32'(count_s),   32'(m_cnt_s));

    @(posedge clk);
    // The pipeline is a pure DEPTH-cycle delay on valid. Data updates only
    // when a valid sample reaches the output.
    exp_q_v.push_back(v);
    exp_q.push_back(d);
    if (exp_q_v.size() >= DEPTH) begin
      pv = exp_q_v.pop_front();
      pd = exp_q.pop_front();
      m_v = pv;
      if (pv) m_d = pd;
    end
    m_sticky = exp_err || (m_sticky && !clr);
    m_cnt    = (clr ? 0 : m_cnt) + (exp_err ? 1 : 0);
    if (m_cnt > (1 << CNT_W) - 1) m_cnt = (1 << CNT_W) - 1;
    m_cnt_s  = (clr ? 0 : m_cnt_s) + (exp_err ? 1 : 0);
    if (m_cnt_s > (1 << CNT_S) - 1) m_cnt_s = (1 << CNT_S) - 1;

    #1;
    if (mode == FLT_DATA) begin
      release dut.b_fin_data;
      release dut_sat.b_fin_data;
    end else if (mode == FLT_VALID) begin
      release dut.b_fin_valid;
      release dut_sat.b_fin_valid;
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"},  32'(out_data),  32'd0);
    check({tag, "_error"},     32'(err),       32'd0);
    check({tag, "_sticky"},    32'(sticky),    32'd0);
    check({tag, "_count"},     32'(count),     32'd0);
    check({tag, "_sat_count"}, 32'(count_s),   32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    clear    = 1'b0;
    f_valid  = 1'b0;
    f_data   = '0;
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fault-free stream followed by idle cycles.
    step(1'b1, 8'h11, 1'b0, FLT_NONE, 8'h00);
    step(1'b1, 8'h22, 1'b0, FLT_NONE, 8'h00);
    step(1'b1, 8'h33, 1'b0, FLT_NONE, 8'h00);
    step(1'b0, 8'h00, 1'b0, FLT_NONE, 8'h00);
    step(1'b0, 8'h00, 1'b0, FLT_NONE, 8'h00);
    step(1'b0, 8'h00, 1'b0, FLT_NONE, 8'h00);

    // Bubble hold: the data stays at 0xA5 after its valid has passed.
    step(1'b1, 8'hA5, 1'b0, FLT_NONE, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h5A, 1'b0, FLT_NONE, 8'h00);

    // A data difference while both copies are invalid is not an error.
    step(1'b0, 8'h00, 1'b0, FLT_DATA, 8'hFF);

    // Single data fault: flip bit 0 on copy B while port_out shows 0x22.
    step(1'b1, 8'h11, 1'b0, FLT_NONE, 8'h00);
    step(1'b1, 8'h22, 1'b0, FLT_NONE, 8'h00);
    step(1'b1, 8'h33, 1'b0, FLT_NONE, 8'h00);
    step(1'b0, 8'h00, 1'b0, FLT_DATA, 8'h01);
    step(1'b0, 8'h00, 1'b0, FLT_NONE, 8'h00);
    step(1'b0, 8'h00, 1'b0, FLT_NONE, 8'h00);

    // Valid fault while copy A is idle, then a second one coinciding with clear.
    step(1'b0, 8'h00, 1'b0, FLT_VALID, 8'h00);
    step(1'b0, 8'h00, 1'b1, FLT_VALID, 8'h00);
    step(1'b0, 8'h00, 1'b0, FLT_NONE, 8'h00);

    // Saturation of the 2-bit counter, then clear with no error.
    step(1'b0, 8'h00, 1'b1, FLT_NONE, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, FLT_VALID, 8'h00);
    step(1'b0, 8'h00, 1'b1, FLT_NONE, 8'h00);
    step(1'b0, 8'h00, 1'b0, FLT_NONE, 8'h00);

    // Reset mid-operation with count=2 and two samples in flight.
    step(1'b0, 8'h00, 1'b0, FLT_VALID, 8'h00);
    step(1'b0, 8'h00, 1'b0, FLT_VALID, 8'h00);
    step(1'b1, 8'h77, 1'b0, FLT_NONE, 8'h00);
    step(1'b1, 8'h88, 1'b0, FLT_NONE, 8'h00);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    check_all_zero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, FLT_NONE, 8'h00);
    step(1'b1, 8'h99, 1'b0, FLT_NONE, 8'h00);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'h00, 1'b0, FLT_NONE, 8'h00);

    // Randomized traffic with occasional clears and injected faults.
    for (int i = 0; i < 400; i++) begin
      logic             rv;
      logic [WIDTH-1:0] rd;
      logic             rc;
      int               rm;
      logic [WIDTH-1:0] rk;
      rv = ($urandom_range(0, 3) != 0);
      rd = WIDTH'($urandom_range(0, 255));
      rc = ($urandom_range(0, 15) == 0);
      rm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : FLT_NONE;
      rk = WIDTH'($urandom_range(0, 255));
      step(rv, rd, rc, rm, rk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dwc_pipeline_checker.md
Name: dwc_pipeline_checker

Overview:
- Parametrised, sequential duplication-with-comparison (DwC) block.
- Two independent copies (A, B) of a DEPTH-stage, WIDTH-bit registered pipeline are fed the same input stream, and their final stages are compared every cycle.
- Raises a per-cycle error pulse, a sticky error flag and a saturating error counter.
- Sits on protected datapaths and is the fault-injection target for register-level DwC studies.

Parameters:
- WIDTH, 8: data width of each pipeline copy; must be >= 1.
- DEPTH, 2: number of register stages per copy, equal to the latency; must be >= 1.
- CNT_W, 8: width of the error counter; must be >= 1.

Ports:
- port_clk  input  1  clock; all state updates on rising edge.
- port_rst_n  input  1  asynchronous active-low reset.
- port_in_valid  input  1  input sample valid.
- port_in  input  WIDTH  input sample.
- port_clear  input  1  synchronous clear of sticky flag and counter.
- port_out_valid  output  1  valid from copy A final stage.
- port_out  output  WIDTH  data from copy A final stage.
- port_error  output  1  combinational mismatch of the final stages, this cycle.
- port_error_sticky  output  1  latched error flag.
- port_error_count  output  CNT_W  number of error cycles, saturating.

Behaviour:
- Interface (already decided): one clock, port_clk. Reset port_rst_n is asynchronous and active-low.
- Reset:
  - On port_rst_n=0, every valid and data register in both copies clears to 0 immediately, without waiting for a clock edge.
  - Sticky flag and counter clear to 0.
  - Outputs while in reset: port_out_valid=0, port_out=0, port_error=0, port_error_sticky=0, port_error_count=0.
  - Reset asserted mid-stream discards all in-flight samples. After release, the first valid output appears DEPTH cycles after the first accepted port_in_valid.
- Pipeline (each copy, identical and structurally separate):
  - Stage k valid is loaded from stage k-1 valid every cycle; stage 0 takes port_in_valid.
  - Stage k data loads from stage k-1 data only when the upstream valid=1, otherwise it holds.
  - Latency is exactly DEPTH cycles. Bubbles propagate as valid=0 while data holds.
  - Copy B must not be merged with copy A by synthesis: apply keep/dont_touch on copy B registers.
- Comparison (final stage, A vs B):
  - port_error = (vA != vB) | (vA & vB & (dA != dB)).
  - Data differences while both valids are 0 are ignored.
  - port_error is combinational from the registers, with no added latency, so it aligns with port_out.
- Sticky flag:
  - Next value = port_error | (sticky & ~port_clear).
  - If port_clear and port_error occur in the same cycle, set wins: sticky=1.
- Counter:
  - Next value = (port_clear ? 0 : count) + port_error, saturating at 2^CNT_W-1.
  - Simultaneous port_clear and port_error gives 1.
  - At saturation the counter holds; it never wraps.
- port_out and port_out_valid always come from copy A, including while port_error=1. Copy B drives only the comparator.
- No other state; the block has no FSM beyond the sticky flag and counter.

Test Plan:
- Fault-free stream, WIDTH=8, DEPTH=2: drive valid samples 0x11, 0x22, 0x33 on consecutive cycles -> port_out shows 0x11/0x22/0x33 with valid=1 on cycles 2/3/4; port_error=0 throughout; count=0.
- Bubble hold: send 0xA5 with valid, then 3 idle cycles -> port_out stays 0xA5 with port_out_valid=0 after the sample passes; port_error=0.
- Single fault: force a bit flip on copy B stage 1 data, turning 0x22 into 0x23 -> port_error=1 for exactly one cycle, aligned with port_out=0x22; sticky=1; count=1.
- Valid fault: force copy B final valid to 1 while copy A valid is 0 -> port_error=1; then pulse port_clear in the same cycle as a second error -> sticky stays 1, count=1.
- Saturation, CNT_W=2: inject 5 error cycles -> count goes 1, 2, 3, 3, 3; port_clear with no error -> count=0, sticky=0.
- Reset mid-operation: assert port_rst_n=0 between clock edges with 2 samples in flight and count=2 -> all outputs are 0 immediately; after release, idle input keeps port_out_valid=0 and the next sample emerges DEPTH cycles after acceptance.
